alu_regs: RTL and testbench

Datapath block directly upstream of the control unit. It holds the two general-purpose 8-bit registers, the 8-bit ALU with its registered result, and the N/NZ flag register. The control unit uses those flags, together with the current instruction and step, to address its control store. All control inputs come straight from the control unit's decoded outputs. The block drives the shared 8-bit data bus through output-enable semantics.

---
 rtl/alu_regs_if.sv | 30 +++
 rtl/alu_regs.sv | 101 ++++++++++
 tb/tb_alu_regs.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_regs_if.sv
// Bus and control bundle between the control unit (master) and the alu_regs datapath (slave).
interface alu_regs_if;
    logic [7:0] i_bus;
    logic [7:0] o_bus;
    logic       o_busDrive;
    logic       o_busConflict;
    logic       i_ctrlRegWr0;
    logic       i_ctrlRegWr1;
    logic       i_ctrlRegBusSel;
    logic       i_ctrlRegNBusEn;
    logic       i_ctrlAluSel;
    logic [1:0] i_ctrlAluOp;
    logic       i_ctrlAluSubShiftDir;
    logic       i_ctrlAluWr;
    logic       i_ctrlAluNOE;
    logic       o_aluFlagN;
    logic       o_aluFlagNZ;

    modport slave (
        input  i_bus, i_ctrlRegWr0, i_ctrlRegWr1, i_ctrlRegBusSel, i_ctrlRegNBusEn,
               i_ctrlAluSel, i_ctrlAluOp, i_ctrlAluSubShiftDir, i_ctrlAluWr, i_ctrlAluNOE,
        output o_bus, o_busDrive, o_busConflict, o_aluFlagN, o_aluFlagNZ
    );

    modport master (
        output i_bus, i_ctrlRegWr0, i_ctrlRegWr1, i_ctrlRegBusSel, i_ctrlRegNBusEn,
               i_ctrlAluSel, i_ctrlAluOp, i_ctrlAluSubShiftDir, i_ctrlAluWr, i_ctrlAluNOE,
        input  o_bus, o_busDrive, o_busConflict, o_aluFlagN, o_aluFlagNZ
    );
endinterface

// File: rtl/alu_regs.sv
// Two 8-bit general registers, an 8-bit ALU with registered result, and the N/NZ flags
// feeding the control unit's store address; drives the shared data bus by output enable.
module alu_regs (
    input  logic      i_clk,
    input  logic      i_reset,
    alu_regs_if.slave bus
);

    logic [7:0] r0_r;
    logic [7:0] r1_r;
    logic [7:0] result_r;
    logic       flagN_r;
    logic       flagNZ_r;

    logic [7:0] opA_s;
    logic [7:0] opB_s;
    logic [7:0] aluOut_s;

    // Operand ordering and ALU function; reads only the registered operands.
    always_comb begin
        opA_s    = 8'h00;
        opB_s    = 8'h00;
        aluOut_s = 8'h00;
        if (bus.i_ctrlAluSel == 1'b1) begin
            opA_s = r1_r;
            opB_s = r0_r;
        end else begin
            opA_s = r0_r;
            opB_s = r1_r;
        end
        case (bus.i_ctrlAluOp)
            2'b00: begin
                if (bus.i_ctrlAluSubShiftDir == 1'b1) begin
                    aluOut_s = opA_s + ~opB_s + 8'd1;
                end else begin
                    aluOut_s = opA_s + opB_s;
                end
            end
            2'b01: aluOut_s = opA_s & opB_s;
            2'b10: aluOut_s = opA_s | opB_s;
            2'b11: begin
                if (bus.i_ctrlAluSubShiftDir == 1'b1) begin
                    aluOut_s = {1'b0, opA_s[7:1]};
                end else begin
                    aluOut_s = {opA_s[6:0], 1'b0};
                end
            end
            default: aluOut_s = 8'h00;
        endcase
    end

    // General registers load from the bus; the bus is the only write path.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r0_r <= 8'h00;
            r1_r <= 8'h00;
        end else begin
            if (bus.i_ctrlRegWr0) begin
                r0_r <= bus.i_bus;
            end
            if (bus.i_ctrlRegWr1) begin
                r1_r <= bus.i_bus;
            end
        end
    end

    // Result and flags change only on a capture edge so the store address stays stable.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            result_r <= 8'h00;
            flagN_r  <= 1'b0;
            flagNZ_r <= 1'b0;
        end else if (bus.i_ctrlAluWr) begin
            result_r <= aluOut_s;
            flagN_r  <= aluOut_s[7];
            flagNZ_r <= |aluOut_s;
        end
    end

    // Bus source select: the ALU result wins when both sources are enabled.
    always_comb begin
        bus.o_bus = 8'h00;
        if (bus.i_ctrlAluNOE == 1'b0) begin
            bus.o_bus = result_r;
        end else if (bus.i_ctrlRegNBusEn == 1'b0) begin
            if (bus.i_ctrlRegBusSel == 1'b1) begin
                bus.o_bus = r1_r;
            end else begin
                bus.o_bus = r0_r;
            end
        end else begin
            bus.o_bus = 8'h00;
        end
    end

    assign bus.o_busDrive    = ~bus.i_ctrlAluNOE | ~bus.i_ctrlRegNBusEn;
    assign bus.o_busConflict = ~bus.i_ctrlAluNOE & ~bus.i_ctrlRegNBusEn;
    assign bus.o_aluFlagN    = flagN_r;
    assign bus.o_aluFlagNZ   = flagNZ_r;

endmodule

// File: tb/tb_alu_regs.sv
// Directed-vector bench for alu_regs: one task per feature, inline comparisons.
module tb_alu_regs;

    logic i_clk;
    logic i_reset;
    int   checks;
    int   errors;

    alu_regs_if busIf ();

    alu_regs dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (busIf.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        busIf.i_bus                = 8'h00;
        busIf.i_ctrlRegWr0         = 1'b0;
        busIf.i_ctrlRegWr1         = 1'b0;
        busIf.i_ctrlRegBusSel      = 1'b0;
        busIf.i_ctrlRegNBusEn      = 1'b1;
        busIf.i_ctrlAluSel         = 1'b0;
        busIf.i_ctrlAluOp          = 2'b00;
        busIf.i_ctrlAluSubShiftDir = 1'b0;
        busIf.i_ctrlAluWr          = 1'b0;
        busIf.i_ctrlAluNOE         = 1'b1;
    endtask

    task automatic loadRegs(input logic [7:0] a, input logic [7:0] b);
        busIf.i_ctrlRegWr0 = 1'b1;
        busIf.i_bus        = a;
        tick();
        busIf.i_ctrlRegWr0 = 1'b0;
        busIf.i_ctrlRegWr1 = 1'b1;
        busIf.i_bus        = b;
        tick();
        busIf.i_ctrlRegWr1 = 1'b0;
        busIf.i_bus        = 8'h00;
    endtask

    task automatic capture(input logic sel, input logic [1:0] op, input logic dir);
        busIf.i_ctrlAluSel         = sel;
        busIf.i_ctrlAluOp          = op;
        busIf.i_ctrlAluSubShiftDir = dir;
        busIf.i_ctrlAluWr          = 1'b1;
        tick();
        busIf.i_ctrlAluWr  = 1'b0;
        busIf.i_ctrlAluNOE = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        i_reset = 1'b1;
        busIf.i_ctrlAluNOE = 1'b0;
        #3;
        checks++;
        if (busIf.o_bus !== 8'h00 || busIf.o_aluFlagN !== 1'b0 || busIf.o_aluFlagNZ !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: bus=%h N=%b NZ=%b, expected bus=00 N=0 NZ=0",
                     busIf.o_bus, busIf.o_aluFlagN, busIf.o_aluFlagNZ);
        end
        i_reset = 1'b0;
        idle();
        tick();
        busIf.i_ctrlRegWr0 = 1'b1;
        busIf.i_bus        = 8'h55;
        tick();
        busIf.i_ctrlRegWr0    = 1'b0;
        busIf.i_ctrlRegNBusEn = 1'b0;
        #1;
        checks++;
        if (busIf.o_bus !== 8'h55) begin
            errors++;
            $display("FAIL reset_preload_r0: got %h expected 55", busIf.o_bus);
        end
        i_reset = 1'b1;
        #1;
        checks++;
        if (busIf.o_bus !== 8'h00) begin
            errors++;
            $display("FAIL reset_async_clear: got %h expected 00", busIf.o_bus);
        end
        busIf.i_ctrlRegWr0 = 1'b1;
        busIf.i_bus        = 8'h77;
        tick();
        checks++;
        if (busIf.o_bus !== 8'h00) begin
            errors++;
            $display("FAIL reset_blocks_write: got %h expected 00", busIf.o_bus);
        end
        i_reset = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_sub();
        idle();
        loadRegs(8'h05, 8'h03);
        capture(1'b0, 2'b00, 1'b1);
        checks++;
        if (busIf.o_bus !== 8'h02 || busIf.o_aluFlagN !== 1'b0 || busIf.o_aluFlagNZ !== 1'b1) begin
            errors++;
            $display("FAIL sub_ab: got %h N=%b NZ=%b expected 02 N=0 NZ=1",
                     busIf.o_bus, busIf.o_aluFlagN, busIf.o_aluFlagNZ);
        end
        idle();
        capture(1'b1, 2'b00, 1'b1);
        checks++;
        if (busIf.o_bus !== 8'hFE || busIf.o_aluFlagN !== 1'b1 || busIf.o_aluFlagNZ !== 1'b1) begin
            errors++;
            $display("FAIL sub_ba: got %h N=%b NZ=%b expected fe N=1 NZ=1",
                     busIf.o_bus, busIf.o_aluFlagN, busIf.o_aluFlagNZ);
        end
    endtask

    task automatic test_logic();
        idle();
        loadRegs(8'hC8, 8'h38);
        capture(1'b0, 2'b00, 1'b0);
        checks++;
        if (busIf.o_bus !== 8'h00 || busIf.o_aluFlagN !== 1'b0 || busIf.o_aluFlagNZ !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap: got %h N=%b NZ=%b expected 00 N=0 NZ=0",
                     busIf.o_bus, busIf.o_aluFlagN, busIf.o_aluFlagNZ);
        end
        idle();
        loadRegs(8'hF0, 8'h0F);
        capture(1'b0, 2'b01, 1'b1);
        checks++;
        if (busIf.o_bus !== 8'h00 || busIf.o_aluFlagN !== 1'b0 || busIf.o_aluFlagNZ !== 1'b0) begin
            errors++;
            $display("FAIL and_zero: got %h N=%b NZ=%b expected 00 N=0 NZ=0",
                     busIf.o_bus, busIf.o_aluFlagN, busIf.o_aluFlagNZ);
        end
        idle();
        capture(1'b0, 2'b10, 1'b1);
        checks++;
        if (busIf.o_bus !== 8'hFF || busIf.o_aluFlagN !== 1'b1 || busIf.o_aluFlagNZ !== 1'b1) begin
            errors++;
            $display("FAIL or_ones: got %h N=%b NZ=%b expected ff N=1 NZ=1",
                     busIf.o_bus, busIf.o_aluFlagN, busIf.o_aluFlagNZ);
        end
    endtask

    task automatic test_shift();
        idle();
        loadRegs(8'h81, 8'h7E);
        capture(1'b0, 2'b11, 1'b0);
        checks++;
        if (busIf.o_bus !== 8'h02 || busIf.o_aluFlagN !== 1'b0 || busIf.o_aluFlagNZ !== 1'b1) begin
            errors++;
            $display("FAIL shift_left: got %h N=%b NZ=%b expected 02 N=0 NZ=1",
                     busIf.o_bus, busIf.o_aluFlagN, busIf.o_aluFlagNZ);
        end
        idle();
        capture(1'b0, 2'b11, 1'b1);
        checks++;
        if (busIf.o_bus !== 8'h40 || busIf.o_aluFlagN !== 1'b0 || busIf.o_aluFlagNZ !== 1'b1) begin
            errors++;
            $display("FAIL shift_right: got %h N=%b NZ=%b expected 40 N=0 NZ=1",
                     busIf.o_bus, busIf.o_aluFlagN, busIf.o_aluFlagNZ);
        end
        // Operands change and the ALU would now produce 0xFE, but no capture is requested.
        idle();
        loadRegs(8'hFF, 8'h00);
        busIf.i_ctrlAluOp  = 2'b11;
        busIf.i_ctrlAluNOE = 1'b0;
        tick();
        checks++;
        if (busIf.o_bus !== 8'h40 || busIf.o_aluFlagN !== 1'b0 || busIf.o_aluFlagNZ !== 1'b1) begin
            errors++;
            $display("FAIL flags_hold: got %h N=%b NZ=%b expected 40 N=0 NZ=1",
                     busIf.o_bus, busIf.o_aluFlagN, busIf.o_aluFlagNZ);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        loadRegs(8'h10, 8'h01);
        busIf.i_ctrlRegWr0 = 1'b1;
        busIf.i_bus        = 8'h20;
        capture(1'b0, 2'b00, 1'b0);
        busIf.i_ctrlRegWr0 = 1'b0;
        checks++;
        if (busIf.o_bus !== 8'h11) begin
            errors++;
            $display("FAIL same_edge_add: got %h expected 11", busIf.o_bus);
        end
        idle();
        capture(1'b0, 2'b00, 1'b0);
        checks++;
        if (busIf.o_bus !== 8'h21) begin
            errors++;
            $display("FAIL next_add: got %h expected 21", busIf.o_bus);
        end
    endtask

    task automatic test_bus();
        idle();
        busIf.i_ctrlRegNBusEn = 1'b0;
        busIf.i_ctrlRegBusSel = 1'b1;
        #1;
        checks++;
        if (busIf.o_bus !== 8'h01 || busIf.o_busDrive !== 1'b1 || busIf.o_busConflict !== 1'b0) begin
            errors++;
            $display("FAIL bus_r1: got %h drive=%b conflict=%b expected 01 drive=1 conflict=0",
                     busIf.o_bus, busIf.o_busDrive, busIf.o_busConflict);
        end
        busIf.i_ctrlRegBusSel = 1'b0;
        #1;
        checks++;
        if (busIf.o_bus !== 8'h20) begin
            errors++;
            $display("FAIL bus_r0: got %h expected 20", busIf.o_bus);
        end
        busIf.i_ctrlAluNOE = 1'b0;
        #1;
        checks++;
        if (busIf.o_bus !== 8'h21 || busIf.o_busDrive !== 1'b1 || busIf.o_busConflict !== 1'b1) begin
            errors++;
            $display("FAIL bus_conflict: got %h drive=%b conflict=%b expected 21 drive=1 conflict=1",
                     busIf.o_bus, busIf.o_busDrive, busIf.o_busConflict);
        end
        idle();
        #1;
        checks++;
        if (busIf.o_bus !== 8'h00 || busIf.o_busDrive !== 1'b0 || busIf.o_busConflict !== 1'b0) begin
            errors++;
            $display("FAIL bus_idle: got %h drive=%b conflict=%b expected 00 drive=0 conflict=0",
                     busIf.o_bus, busIf.o_busDrive, busIf.o_busConflict);
        end
        // Register move r0 -> r1: the external mux returns r0 (0x20) on i_bus.
        busIf.i_ctrlRegNBusEn = 1'b0;
        busIf.i_ctrlRegBusSel = 1'b0;
        busIf.i_bus           = 8'h20;
        busIf.i_ctrlRegWr1    = 1'b1;
        tick();
        busIf.i_ctrlRegWr1    = 1'b0;
        busIf.i_ctrlRegBusSel = 1'b1;
        #1;
        checks++;
        if (busIf.o_bus !== 8'h20) begin
            errors++;
            $display("FAIL move_r0_r1: got %h expected 20", busIf.o_bus);
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sub();
        test_logic();
        test_shift();
        test_back_to_back();
        test_bus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
